// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snake_pkg
// Brief   : Shared types and constants for the snake renderer.
//           Includes the pixel codes, the render/paint state encodings,
//           and the segment extraction helper.
// Revision: 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam int GRID_CELLS  = 256;
  localparam int SEG_ADDR_W  = 8;
  localparam int SEG_SLOTS   = 16;
  localparam int SEG_IDX_W   = 4;
  localparam int SEG_FLAT_W  = SEG_SLOTS * SEG_ADDR_W;

  localparam logic [1:0] PIX_EMPTY = 2'b00;
  localparam logic [1:0] PIX_BODY  = 2'b01;
  localparam logic [1:0] PIX_HEAD  = 2'b10;
  localparam logic [1:0] PIX_FOOD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } render_state_t;

  // Sub-steps of PAINT: body segments (tail first), then food, then head last
  // so that later writes give the priority head > food > body.
  typedef enum logic [1:0] {
    PH_BODY = 2'd0,
    PH_FOOD = 2'd1,
    PH_HEAD = 2'd2
  } paint_phase_t;

  // Segment k is packed MSB-first: segment 0 (head) sits in the top byte.
  function automatic logic [SEG_ADDR_W-1:0] seg(
    input logic [SEG_FLAT_W-1:0] flat,
    input logic [SEG_IDX_W-1:0]  k
  );
    return flat[SEG_FLAT_W - 1 - SEG_ADDR_W * int'(k) -: SEG_ADDR_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_fb.sv
`default_nettype none
// ============================================================================
// Module  : snake_fb
// Brief   : Two-bit-per-cell framebuffer with synchronous clear-all, one
//           write port and one registered read port.  A read of the cell
//           being written in the same cycle returns the new data.
// Revision: 1.0 - initial release
// ============================================================================
module snake_fb
  import snake_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              i_clear,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [1:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [1:0]        o_rd_data
);

  localparam int c_CELLS = 2 ** ADDR_W;

  logic [1:0] r_mem [c_CELLS];
  logic [1:0] r_rd_data;

  // Cell storage: clear-all has priority over the single write port.
  always_ff @(posedge Clk) begin
    if (i_clear) begin
      for (int i = 0; i < c_CELLS; i++) begin
        r_mem[i] <= PIX_EMPTY;
      end
    end else if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read with write-through so the last paint write is visible
  // to the first scan pixel without an extra cycle.
  always_ff @(posedge Clk) begin
    if (i_clear) begin
      r_rd_data <= PIX_EMPTY;
    end else if (i_we && (i_wr_addr == i_rd_addr)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/snake_render.sv
`default_nettype none
// ============================================================================
// Module  : snake_render
// Brief   : Snapshots the snake game state on request, paints a framebuffer
//           and streams every cell in raster order over valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module snake_render
  import snake_pkg::*;
#(
  parameter int GRID_BITS = 4,
  parameter int MAX_SEG   = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Frame_Start,
  input  logic [2*GRID_BITS-1:0]       Food,
  input  logic [$clog2(MAX_SEG)-1:0]   Length,
  input  logic [MAX_SEG*2*GRID_BITS-1:0] Locations_Flat,
  output logic                         Pix_Valid,
  input  logic                         Pix_Ready,
  output logic [2*GRID_BITS-1:0]       Pix_Addr,
  output logic [1:0]                   Pix_Data,
  output logic                         Busy,
  output logic                         Frame_Done
);

  localparam int c_AW = 2 * GRID_BITS;
  localparam int c_LW = $clog2(MAX_SEG);

  render_state_t            r_state, w_state_nxt;
  paint_phase_t             r_phase, w_phase_nxt;
  logic [c_LW-1:0]          r_paint_idx, w_paint_nxt;
  logic                     r_valid, w_valid_nxt;
  logic [c_AW-1:0]          r_addr, w_addr_nxt;
  logic [c_AW-1:0]          r_food;
  logic [MAX_SEG*c_AW-1:0]  r_locs;

  logic                     w_load;
  logic                     w_clear;
  logic                     w_we;
  logic [c_AW-1:0]          w_wr_addr;
  logic [1:0]               w_wr_data;
  logic [c_AW-1:0]          w_rd_addr;
  logic [1:0]               w_rd_data;
  logic                     w_handshake;

  assign w_handshake = r_valid & Pix_Ready;

  // Next-state, paint sequencing and scan counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_paint_nxt = r_paint_idx;
    w_valid_nxt = r_valid;
    w_addr_nxt  = r_addr;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_we        = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = PIX_EMPTY;
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        w_addr_nxt  = '0;
        if (Frame_Start) begin
          w_load      = 1'b1;
          w_clear     = 1'b1;
          w_paint_nxt = Length;
          w_phase_nxt = (Length == '0) ? PH_FOOD : PH_BODY;
          w_state_nxt = ST_PAINT;
        end
      end
      ST_PAINT: begin
        w_we = 1'b1;
        case (r_phase)
          PH_BODY: begin
            w_wr_addr = seg(r_locs, r_paint_idx);
            w_wr_data = PIX_BODY;
            if (r_paint_idx == c_LW'(1)) begin
              w_phase_nxt = PH_FOOD;
            end else begin
              w_paint_nxt = r_paint_idx - 1'b1;
            end
          end
          PH_FOOD: begin
            w_wr_addr   = r_food;
            w_wr_data   = PIX_FOOD;
            w_phase_nxt = PH_HEAD;
          end
          default: begin
            w_wr_addr   = seg(r_locs, '0);
            w_wr_data   = PIX_HEAD;
            w_state_nxt = ST_SCAN;
            w_valid_nxt = 1'b1;
            w_addr_nxt  = '0;
          end
        endcase
      end
      ST_SCAN: begin
        if (w_handshake) begin
          if (&r_addr) begin
            w_state_nxt = ST_DONE;
            w_valid_nxt = 1'b0;
            w_addr_nxt  = '0;
          end else begin
            w_addr_nxt = r_addr + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_addr_nxt  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Paint index, phase and scan output registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_phase     <= PH_BODY;
      r_paint_idx <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_paint_idx <= w_paint_nxt;
      r_valid     <= w_valid_nxt;
      r_addr      <= w_addr_nxt;
    end
  end

  // Game-state snapshot so the core may update freely mid-frame.
  always_ff @(posedge Clk) begin
    if (w_load) begin
      r_food <= Food;
      r_locs <= Locations_Flat;
    end
  end

  // Read one cell ahead on acceptance so Pix_Data tracks Pix_Addr with no bubble.
  assign w_rd_addr = (r_state == ST_SCAN && w_handshake) ? r_addr + 1'b1 : r_addr;

  snake_fb #(
    .ADDR_W (c_AW)
  ) u_fb (
    .Clk       (Clk),
    .i_clear   (w_clear & Reset),
    .i_we      (w_we & Reset),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign Pix_Valid  = r_valid;
  assign Pix_Addr   = r_addr;
  assign Pix_Data   = r_valid ? w_rd_data : PIX_EMPTY;
  assign Busy       = (r_state != ST_IDLE);
  assign Frame_Done = (r_state == ST_DONE);

endmodule
`default_nettype wire
